config_loader: RTL

Configuration loader that sits directly upstream of a logic tile and produces its `config_in` vector. It accepts a word-serial bitstream over a valid/ready handshake, assembles the bits in a shadow register, and commits the full vector to a stable output register only after the last word is received. The fabric therefore never sees a partially loaded configuration.

---
 rtl/config_loader.sv | 93 +++++++++
 1 files changed

// File: rtl/config_loader.sv
// Word-serial configuration loader: assembles a bitstream in a shadow register and
// commits it atomically to config_out so the tile never sees a partial configuration.
module config_loader #(
    parameter int CONFIG_WIDTH = 644,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    start,
    input  logic [WORD_WIDTH-1:0]   data_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    output logic                    busy,
    output logic                    config_done,
    output logic [CONFIG_WIDTH-1:0] config_out
);

    localparam int NWORDS   = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int CNT_W    = $clog2(NWORDS + 1);
    localparam int SHADOW_W = NWORDS * WORD_WIDTH;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                  state_q,  state_d;
    logic [CNT_W-1:0]        count_q,  count_d;
    logic [SHADOW_W-1:0]     shadow_q, shadow_d;
    logic [CONFIG_WIDTH-1:0] config_q, config_d;
    logic                    done_q,   done_d;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            shadow_q <= '0;
            config_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
            config_q <= config_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shadow_d = shadow_q;
        config_d = config_q;
        done_d   = done_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    count_d = '0;
                    done_d  = 1'b0;
                end
            end
            LOAD: begin
                // A restart wins over a word presented on the same edge; that word is dropped.
                if (start) begin
                    count_d = '0;
                end else if (data_valid) begin
                    shadow_d = {data_in, shadow_q[SHADOW_W-1:WORD_WIDTH]};
                    count_d  = count_q + CNT_W'(1);
                    if (count_q == LAST_IDX) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                config_d = shadow_q[CONFIG_WIDTH-1:0];
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_ready  = (state_q == LOAD);
    assign busy        = (state_q != IDLE);
    assign config_done = done_q;
    assign config_out  = config_q;

endmodule
